// File: rtl/oc0a_perst_seq.sv
// ----------------------------------------------------------------------------
// oc0a_perst_seq
//
// PERST# sequencer for the downstream NVMe SSD port (oc0a). Holds the SSD in
// PERST# until the host slot is out of reset and the oc0a reference clock is
// locked. It then enforces the minimum PERST# low time, releases the
// root-port core reset a fixed lead time ahead of PERST#, and supervises
// link training with a timeout and a bounded number of retries.
//
// Optional feature (compile-time macro):
//   OC0A_PERST_LINKDOWN_RETRY_EN
//     defined   : a link_up loss while UP counts as a failed attempt and
//                 re-sequences (or goes to FAIL once retries are used up).
//     undefined : UP ignores link_up loss; recovery is left to software
//                 via sw_reset_req.
//
// Ports:
//   clk           in   free-running system clock
//   rst           in   asynchronous active-high reset
//   host_perstn   in   host slot PERST# (async, 2-FF synchronized here)
//   refclk_locked in   oc0a GT PLL lock (async, 2-FF synchronized here)
//   link_up       in   root-port DL_Up, synchronous to clk
//   sw_reset_req  in   one-cycle pulse, restart the sequence from HOLD
//   oc0a_perstn   out  PERST# to the SSD (registered)
//   rp_rst        out  active-high reset to the root-port core (registered)
//   link_fail     out  retries exhausted (registered, high while in FAIL)
//   state         out  FSM state: HOLD=0 PERST_MIN=1 RP_LEAD=2 TRAIN=3
//                      UP=4 FAIL=5
//   retry_cnt     out  failed training attempts in the current sequence
// ----------------------------------------------------------------------------
module oc0a_perst_seq #(
    parameter int T_PERST_MIN_CYC     = 25_000_000,
    parameter int T_TRAIN_TIMEOUT_CYC = 50_000_000,
    parameter int T_RP_LEAD_CYC       = 256,
    parameter int MAX_RETRIES         = 3,
    localparam int RETRY_W            = $clog2(MAX_RETRIES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               host_perstn,
    input  logic               refclk_locked,
    input  logic               link_up,
    input  logic               sw_reset_req,
    output logic               oc0a_perstn,
    output logic               rp_rst,
    output logic               link_fail,
    output logic [2:0]         state,
    output logic [RETRY_W-1:0] retry_cnt
);

    // One shared phase counter, sized for the longest interval it must reach.
    localparam int CNT_MAX_A = (T_PERST_MIN_CYC > T_RP_LEAD_CYC) ? T_PERST_MIN_CYC : T_RP_LEAD_CYC;
    localparam int CNT_MAX   = (T_TRAIN_TIMEOUT_CYC > CNT_MAX_A) ? T_TRAIN_TIMEOUT_CYC : CNT_MAX_A;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   PERST_LAST = CNT_W'(T_PERST_MIN_CYC - 1);
    localparam logic [CNT_W-1:0]   LEAD_LAST  = CNT_W'(T_RP_LEAD_CYC - 1);
    localparam logic [CNT_W-1:0]   TRAIN_LAST = CNT_W'(T_TRAIN_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]   CNT_SAT    = '1;
    localparam logic [RETRY_W-1:0] MAX_R      = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_HOLD      = 3'd0,
        S_PERST_MIN = 3'd1,
        S_RP_LEAD   = 3'd2,
        S_TRAIN     = 3'd3,
        S_UP        = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    state_t            st;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              host_s1, host_s2, host_d;
    logic              lock_s1, lock_s2;
    logic              ok;
    logic              host_fall;

    // Input synchronizers; host_d is one extra stage used only to find the
    // falling edge of the synchronized host PERST#.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_s1 <= 1'b0;
            host_s2 <= 1'b0;
            host_d  <= 1'b0;
            lock_s1 <= 1'b0;
            lock_s2 <= 1'b0;
        end else begin
            host_s1 <= host_perstn;
            host_s2 <= host_s1;
            host_d  <= host_s2;
            lock_s1 <= refclk_locked;
            lock_s2 <= lock_s1;
        end
    end

    assign ok        = host_s2 & lock_s2;
    assign host_fall = host_d & ~host_s2;

    // Counter never wraps; it sticks at all-ones if a phase outlives it.
    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);

    assign state = st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= S_HOLD;
            cnt         <= '0;
            retry_cnt   <= '0;
            oc0a_perstn <= 1'b0;
            rp_rst      <= 1'b1;
            link_fail   <= 1'b0;
        end else begin
            // Outputs follow the state held during this cycle, so each
            // output moves one cycle after the state does. That keeps
            // rp_rst falling exactly RP_LEAD cycles ahead of PERST# rising.
            oc0a_perstn <= (st == S_TRAIN) || (st == S_UP);
            rp_rst      <= !((st == S_RP_LEAD) || (st == S_TRAIN) || (st == S_UP));
            link_fail   <= (st == S_FAIL);

            if (sw_reset_req || host_fall) begin
                // Restart requests win over every state-local transition.
                // A host falling edge also implies !ok, so HOLD is right.
                st        <= S_HOLD;
                cnt       <= '0;
                retry_cnt <= '0;
            end else begin
                case (st)
                    S_HOLD: begin
                        cnt <= '0;
                        if (ok) st <= S_PERST_MIN;
                    end

                    S_PERST_MIN: begin
                        if (!ok) begin
                            st  <= S_HOLD;
                            cnt <= '0;
                        end else if (cnt == PERST_LAST) begin
                            st  <= S_RP_LEAD;
                            cnt <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end

                    S_RP_LEAD: begin
                        if (!ok) begin
                            st  <= S_HOLD;
                            cnt <= '0;
                        end else if (cnt == LEAD_LAST) begin
                            st  <= S_TRAIN;
                            cnt <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end

                    S_TRAIN: begin
                        if (!ok) begin
                            st  <= S_HOLD;
                            cnt <= '0;
                        end else if (link_up) begin
                            // link_up beats a timeout landing in the same cycle
                            st  <= S_UP;
                            cnt <= '0;
                        end else if (cnt == TRAIN_LAST) begin
                            cnt <= '0;
                            if (retry_cnt < MAX_R) begin
                                retry_cnt <= retry_cnt + RETRY_W'(1);
                                st        <= S_HOLD;
                            end else begin
                                st <= S_FAIL;
                            end
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end

                    S_UP: begin
                        cnt <= '0;
                        if (!ok) begin
                            st <= S_HOLD;
`ifdef OC0A_PERST_LINKDOWN_RETRY_EN
                        end else if (!link_up) begin
                            if (retry_cnt < MAX_R) begin
                                retry_cnt <= retry_cnt + RETRY_W'(1);
                                st        <= S_HOLD;
                            end else begin
                                st <= S_FAIL;
                            end
`endif
                        end
                    end

                    S_FAIL: begin
                        // Left only through the restart branch above.
                        cnt <= '0;
                    end

                    default: begin
                        st  <= S_HOLD;
                        cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oc0a_perst_seq.sv
// ----------------------------------------------------------------------------
// tb_oc0a_perst_seq
//
// Bench for oc0a_perst_seq with small timing parameters. Each scenario plans
// the state timeline from the sequencing rules (phase lengths, sync latency,
// retry rules) as a list of (cycle, state, retry) points. Expected output
// snapshots are derived from that timeline (outputs reflect the state of the
// previous cycle) and pushed into exp_q before stimulus is driven. A monitor
// pops and compares an entry every time the DUT's visible outputs change.
// ----------------------------------------------------------------------------
module tb_oc0a_perst_seq;

    localparam int PM = 16;
    localparam int TO = 64;
    localparam int RL = 4;
    localparam int MR = 2;
    localparam int RW = 2;
    localparam int EW = 40;

    localparam logic [2:0] HOLD      = 3'd0;
    localparam logic [2:0] PERST_MIN = 3'd1;
    localparam logic [2:0] RP_LEAD   = 3'd2;
    localparam logic [2:0] TRAIN     = 3'd3;
    localparam logic [2:0] UP        = 3'd4;
    localparam logic [2:0] FAIL_ST   = 3'd5;

    // snapshot = {state, perstn, rp_rst, link_fail, retry_cnt}
    localparam logic [7:0] RESET_SNAP = {3'd0, 1'b0, 1'b1, 1'b0, 2'd0};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic host_perstn = 1'b0;
    logic refclk_locked = 1'b0;
    logic link_up = 1'b0;
    logic sw_reset_req = 1'b0;

    logic          oc0a_perstn;
    logic          rp_rst;
    logic          link_fail;
    logic [2:0]    state;
    logic [RW-1:0] retry_cnt;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    oc0a_perst_seq #(
        .T_PERST_MIN_CYC     (PM),
        .T_TRAIN_TIMEOUT_CYC (TO),
        .T_RP_LEAD_CYC       (RL),
        .MAX_RETRIES         (MR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .host_perstn   (host_perstn),
        .refclk_locked (refclk_locked),
        .link_up       (link_up),
        .sw_reset_req  (sw_reset_req),
        .oc0a_perstn   (oc0a_perstn),
        .rp_rst        (rp_rst),
        .link_fail     (link_fail),
        .state         (state),
        .retry_cnt     (retry_cnt)
    );

    // ---------------- reference model ----------------
    logic [EW-1:0] exp_q[$];
    int            tr_c[$];
    logic [2:0]    tr_s[$];
    logic [1:0]    tr_r[$];
    int            m_cyc;
    logic [7:0]    m_prev;

    // Add a timeline point; anything planned at or after it is superseded.
    task automatic add_tr(input int c, input logic [2:0] s, input logic [1:0] r);
        while (tr_c.size() > 0 && tr_c[tr_c.size()-1] >= c) begin
            void'(tr_c.pop_back());
            void'(tr_s.pop_back());
            void'(tr_r.pop_back());
        end
        tr_c.push_back(c);
        tr_s.push_back(s);
        tr_r.push_back(r);
    endtask

    function automatic int tr_idx(input int t);
        for (int i = tr_c.size() - 1; i >= 0; i--) begin
            if (tr_c[i] <= t) return i;
        end
        return 0;
    endfunction

    // Expand the timeline into expected output-change snapshots up to tend.
    task automatic model_emit(input int tend);
        for (int t = m_cyc + 1; t <= tend; t++) begin
            int i;
            int j;
            logic [2:0] sp;
            logic [7:0] snap;
            i = tr_idx(t);
            j = tr_idx(t - 1);
            sp = tr_s[j];
            snap = {tr_s[i], (sp == TRAIN) || (sp == UP),
                    !((sp == RP_LEAD) || (sp == TRAIN) || (sp == UP)),
                    (sp == FAIL_ST), tr_r[i]};
            if (snap !== m_prev) begin
                exp_q.push_back({32'(t), snap});
                m_prev = snap;
            end
        end
        m_cyc = tend;
    endtask

    task automatic model_reset(input int e);
        add_tr(e, HOLD, 2'd0);
        m_prev = RESET_SNAP;
        m_cyc  = e;
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit            mon_en = 1'b0;
    logic [7:0]    mon_prev = RESET_SNAP;
    logic [7:0]    mon_snap;
    logic [EW-1:0] mon_e;

    always @(negedge clk) begin
        if (mon_en) begin
            mon_snap = {state, oc0a_perstn, rp_rst, link_fail, retry_cnt};
            if (mon_snap !== mon_prev) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_change cyc=%0d got state=%0d perstn=%0b rp_rst=%0b link_fail=%0b retry=%0d required no change",
                             cyc, mon_snap[7:5], mon_snap[4], mon_snap[3], mon_snap[2], mon_snap[1:0]);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e !== {32'(cyc), mon_snap}) begin
                        n_err++;
                        $display("FAIL snapshot got cyc=%0d state=%0d perstn=%0b rp_rst=%0b link_fail=%0b retry=%0d required cyc=%0d state=%0d perstn=%0b rp_rst=%0b link_fail=%0b retry=%0d",
                                 cyc, mon_snap[7:5], mon_snap[4], mon_snap[3], mon_snap[2], mon_snap[1:0],
                                 mon_e[39:8], mon_e[7:5], mon_e[4], mon_e[3], mon_e[2], mon_e[1:0]);
                    end
                end
                mon_prev = mon_snap;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d required=%0d", nm, cyc, got, req);
        end
    endtask

    task automatic check_drained();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drained cyc=%0d pending=%0d required=0 next_required_cyc=%0d",
                     cyc, exp_q.size(), exp_q[0][39:8]);
            exp_q.delete();
        end
    endtask

    task automatic finish_scn(input int end_c);
        wait_cyc(end_c + 1);
        check_drained();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_perstn"}, 32'(oc0a_perstn), 32'd0);
        chk({tag, "_rp_rst"}, 32'(rp_rst), 32'd1);
        chk({tag, "_link_fail"}, 32'(link_fail), 32'd0);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_retry"}, 32'(retry_cnt), 32'd0);
    endtask

    task automatic pulse_sw(input int s);
        wait_cyc(s);
        sw_reset_req = 1'b1;
        wait_cyc(s + 1);
        sw_reset_req = 1'b0;
    endtask

    // Plan PERST_MIN at p through a successful bring-up, then an idle drop of
    // both inputs once UP; returns the drive cycles and scenario end.
    task automatic plan_up_idle(input int p, input logic [1:0] r,
                                output int l_c, output int i_c, output int end_c);
        int t;
        t = p + PM + RL;
        add_tr(p, PERST_MIN, r);
        add_tr(p + PM, RP_LEAD, r);
        add_tr(t, TRAIN, r);
        l_c = t + 1 + $urandom_range(40, 1);
        add_tr(l_c + 1, UP, r);
        i_c = l_c + 1 + $urandom_range(10, 2);
        add_tr(i_c + 3, HOLD, 2'd0);
        end_c = i_c + 8;
    endtask

    task automatic drive_up_idle(input int l_c, input int i_c, input int end_c);
        wait_cyc(l_c);
        link_up = 1'b1;
        wait_cyc(i_c);
        host_perstn   = 1'b0;
        refclk_locked = 1'b0;
        link_up       = 1'b0;
        finish_scn(end_c);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int c, p, t, l, k, i, e, s, d, r, ra, end_c;
        int t1, t2, t3;

        // Reset state
        wait_cyc(3);
        rst = 1'b0;
        check_reset_outputs("reset");
        model_reset(3);
        mon_prev = RESET_SNAP;
        mon_en   = 1'b1;

        // Nominal bring-up, then link_up loss while UP
        c = cyc + $urandom_range(10, 2);
        p = c + 3;
        t = p + PM + RL;
        add_tr(p, PERST_MIN, 2'd0);
        add_tr(p + PM, RP_LEAD, 2'd0);
        add_tr(t, TRAIN, 2'd0);
        l = t + 1 + $urandom_range(40, 1);
        add_tr(l + 1, UP, 2'd0);
        k = l + 1 + $urandom_range(20, 3);
`ifdef OC0A_PERST_LINKDOWN_RETRY_EN
        add_tr(k + 1, HOLD, 2'd1);
        add_tr(k + 2, PERST_MIN, 2'd1);
        add_tr(k + 2 + PM, RP_LEAD, 2'd1);
        add_tr(k + 2 + PM + RL, TRAIN, 2'd1);
`endif
        i = k + 5;
        add_tr(i + 3, HOLD, 2'd0);
        end_c = i + 8;
        model_emit(end_c);
        wait_cyc(c);
        host_perstn   = 1'b1;
        refclk_locked = 1'b1;
        wait_cyc(l);
        link_up = 1'b1;
        wait_cyc(k);
        link_up = 1'b0;
        wait_cyc(k + 2);
`ifdef OC0A_PERST_LINKDOWN_RETRY_EN
        chk("linkdrop_retry", 32'(retry_cnt), 32'd1);
`else
        chk("linkdrop_perstn", 32'(oc0a_perstn), 32'd1);
`endif
        wait_cyc(i);
        host_perstn   = 1'b0;
        refclk_locked = 1'b0;
        finish_scn(end_c);

        // Training timeouts to FAIL, software restart, normal bring-up
        c  = cyc + $urandom_range(6, 2);
        t1 = c + 3 + PM + RL;
        add_tr(c + 3, PERST_MIN, 2'd0);
        add_tr(c + 3 + PM, RP_LEAD, 2'd0);
        add_tr(t1, TRAIN, 2'd0);
        add_tr(t1 + TO, HOLD, 2'd1);
        t2 = t1 + TO + 1 + PM + RL;
        add_tr(t1 + TO + 1, PERST_MIN, 2'd1);
        add_tr(t1 + TO + 1 + PM, RP_LEAD, 2'd1);
        add_tr(t2, TRAIN, 2'd1);
        add_tr(t2 + TO, HOLD, 2'd2);
        t3 = t2 + TO + 1 + PM + RL;
        add_tr(t2 + TO + 1, PERST_MIN, 2'd2);
        add_tr(t2 + TO + 1 + PM, RP_LEAD, 2'd2);
        add_tr(t3, TRAIN, 2'd2);
        add_tr(t3 + TO, FAIL_ST, 2'd2);
        s = t3 + TO + $urandom_range(10, 2);
        add_tr(s + 1, HOLD, 2'd0);
        plan_up_idle(s + 2, 2'd0, l, i, end_c);
        model_emit(end_c);
        wait_cyc(c);
        host_perstn   = 1'b1;
        refclk_locked = 1'b1;
        wait_cyc(t3 + TO + 1);
        chk("fail_link_fail", 32'(link_fail), 32'd1);
        chk("fail_perstn", 32'(oc0a_perstn), 32'd0);
        pulse_sw(s);
        drive_up_idle(l, i, end_c);

        // Refclk lock loss inside PERST_MIN, then relock
        c = cyc + $urandom_range(6, 2);
        p = c + 3;
        d = p + $urandom_range(12, 1);
        r = d + $urandom_range(8, 1);
        add_tr(p, PERST_MIN, 2'd0);
        add_tr(d + 3, HOLD, 2'd0);
        plan_up_idle(r + 3, 2'd0, l, i, end_c);
        model_emit(end_c);
        wait_cyc(c);
        host_perstn   = 1'b1;
        refclk_locked = 1'b1;
        wait_cyc(d);
        refclk_locked = 1'b0;
        wait_cyc(r);
        refclk_locked = 1'b1;
        drive_up_idle(l, i, end_c);

        // sw_reset_req landing on the same cycle as a TRAIN timeout
        c  = cyc + $urandom_range(6, 2);
        t1 = c + 3 + PM + RL;
        add_tr(c + 3, PERST_MIN, 2'd0);
        add_tr(c + 3 + PM, RP_LEAD, 2'd0);
        add_tr(t1, TRAIN, 2'd0);
        add_tr(t1 + TO, HOLD, 2'd1);
        t2 = t1 + TO + 1 + PM + RL;
        add_tr(t1 + TO + 1, PERST_MIN, 2'd1);
        add_tr(t1 + TO + 1 + PM, RP_LEAD, 2'd1);
        add_tr(t2, TRAIN, 2'd1);
        add_tr(t2 + TO, HOLD, 2'd0);
        p = t2 + TO + 1;
        add_tr(p, PERST_MIN, 2'd0);
        i = p + $urandom_range(10, 2);
        add_tr(i + 3, HOLD, 2'd0);
        end_c = i + 8;
        model_emit(end_c);
        wait_cyc(c);
        host_perstn   = 1'b1;
        refclk_locked = 1'b1;
        pulse_sw(t2 + TO - 1);
        wait_cyc(i);
        host_perstn   = 1'b0;
        refclk_locked = 1'b0;
        finish_scn(end_c);

        // Asynchronous reset while in TRAIN
        c  = cyc + $urandom_range(6, 2);
        t  = c + 3 + PM + RL;
        ra = t + 1 + $urandom_range(30, 2);
        add_tr(c + 3, PERST_MIN, 2'd0);
        add_tr(c + 3 + PM, RP_LEAD, 2'd0);
        add_tr(t, TRAIN, 2'd0);
        model_emit(ra - 1);
        wait_cyc(c);
        host_perstn   = 1'b1;
        refclk_locked = 1'b1;
        wait_cyc(ra);
        mon_en = 1'b0;
        check_drained();
        chk("pre_rst_perstn", 32'(oc0a_perstn), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        wait_cyc(ra + 2);
        rst = 1'b0;
        e = ra + 2;
        model_reset(e);
        mon_prev = RESET_SNAP;
        mon_en   = 1'b1;
        plan_up_idle(e + 3, 2'd0, l, i, end_c);
        model_emit(end_c);
        drive_up_idle(l, i, end_c);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Run-length bound
    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
